fifo_unpacker: RTL and testbench

Read-side drain stage placed directly downstream of the asynchronous FIFO, in the `clk_out` domain. It pops `datasize`-bit words from the FIFO read port with `remove`/`empty`/`dataOut`. It serialises each word into a stream of `bytesize`-bit beats on a valid/ready interface. It honours the read-domain flush and keeps a running count of completed words.

---
 rtl/fifo_unpacker.sv | 101 ++++++++++
 tb/tb_fifo_unpacker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_unpacker.sv
// Drains words from the async FIFO read port (clk_out domain) and streams them out as
// bytesize-bit beats on a valid/ready interface, counting fully delivered words.
module fifo_unpacker #(
  parameter int unsigned datasize  = 32,
  parameter int unsigned bytesize  = 8,
  parameter bit          msb_first = 1'b0
) (
  input  logic                clk_out,
  input  logic                rst,
  input  logic                sync_flush,
  input  logic                empty,
  input  logic [datasize-1:0] dataOut,
  output logic                remove,
  output logic [bytesize-1:0] byte_out,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic                byte_last,
  output logic [15:0]         word_count
);

  localparam int unsigned Ratio = datasize / bytesize;
  localparam int unsigned IdxW  = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Ratio - 1);

  typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [datasize-1:0] word_q, word_d;
  logic [15:0]         word_count_q, word_count_d;
  logic [IdxW-1:0]     sel;
  logic [bytesize-1:0] beats [Ratio];

  for (genvar i = 0; i < Ratio; i++) begin : g_beats
    assign beats[i] = word_q[i*bytesize +: bytesize];
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    word_d       = word_q;
    word_count_d = word_count_q;
    remove       = 1'b0;
    byte_valid   = 1'b0;
    if (sync_flush) begin
      // Flush wins over everything, including a handshake completing this cycle.
      state_d = StIdle;
      idx_d   = '0;
      word_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Gate with rst so no pop is requested while reset is held.
          remove = rst && !empty;
          if (!empty) state_d = StWait;
        end
        StWait: begin
          word_d  = dataOut;
          idx_d   = '0;
          state_d = StSend;
        end
        StSend: begin
          byte_valid = 1'b1;
          if (byte_ready) begin
            if (idx_q == LastIdx) begin
              word_count_d = word_count_q + 16'd1;
              state_d      = StIdle;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Index holds on the final beat, so byte_out keeps the last beat while idle.
  always_comb begin
    sel       = msb_first ? (LastIdx - idx_q) : idx_q;
    byte_out  = beats[sel];
    byte_last = (state_q == StSend) && (idx_q == LastIdx);
  end

  assign word_count = word_count_q;

  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      word_q       <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      word_count_q <= word_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Scoreboard bench: two instances (LSB-first and MSB-first) share one FIFO model and sink;
// a negedge monitor compares both against a word/beat-level reference model.
module tb_fifo_unpacker;

  localparam int R = 4;

  logic        clk_out = 1'b0;
  logic        rst, sync_flush, empty, byte_ready;
  logic [31:0] dataOut;
  logic        rm [2];
  logic [7:0]  bo [2];
  logic        bv [2];
  logic        bl [2];
  logic [15:0] wc [2];

  fifo_unpacker #(.datasize(32), .bytesize(8), .msb_first(1'b0)) u_dut0 (
    .clk_out(clk_out), .rst(rst), .sync_flush(sync_flush), .empty(empty), .dataOut(dataOut),
    .remove(rm[0]), .byte_out(bo[0]), .byte_valid(bv[0]), .byte_ready(byte_ready),
    .byte_last(bl[0]), .word_count(wc[0])
  );

  fifo_unpacker #(.datasize(32), .bytesize(8), .msb_first(1'b1)) u_dut1 (
    .clk_out(clk_out), .rst(rst), .sync_flush(sync_flush), .empty(empty), .dataOut(dataOut),
    .remove(rm[1]), .byte_out(bo[1]), .byte_valid(bv[1]), .byte_ready(byte_ready),
    .byte_last(bl[1]), .word_count(wc[1])
  );

  always #5 clk_out = ~clk_out;

  typedef struct {logic [31:0] w; int k; bit last;} beat_t;

  int          checks = 0;
  int          failures = 0;
  beat_t       exp_q [$];
  logic [31:0] fifo_q [$];
  bit          inflight = 0;
  int          pop_cyc = 0;
  int          cyc = 0;
  int          beats_done = 0;
  logic [15:0] model_cnt = 0;
  bit          pop_pending = 0;
  bit          hide = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] beat_of(input logic [31:0] w, input int k, input bit msb);
    int j;
    j = msb ? (R - 1 - k) : k;
    return w[j*8 +: 8];
  endfunction

  // FIFO read port: data appears the cycle after an accepted pop, garbage otherwise.
  always @(posedge clk_out) begin
    logic [31:0] tmp;
    if (pop_pending) tmp = fifo_q.pop_front();
    else tmp = $urandom;
    dataOut <= tmp;
  end

  always @(negedge clk_out) begin
    bit exp_valid, exp_remove;
    beat_t b;
    cyc++;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rst dut%0d remove", d), 32'(rm[d]), 0);
        chk($sformatf("rst dut%0d valid", d), 32'(bv[d]), 0);
        chk($sformatf("rst dut%0d last", d), 32'(bl[d]), 0);
        chk($sformatf("rst dut%0d byte_out", d), 32'(bo[d]), 0);
        chk($sformatf("rst dut%0d word_count", d), 32'(wc[d]), 0);
      end
      exp_q.delete();
      inflight    = 0;
      beats_done  = 0;
      model_cnt   = 0;
      pop_pending = 0;
    end else begin
      exp_valid  = inflight && (cyc - pop_cyc >= 2) && !sync_flush;
      exp_remove = !empty && !sync_flush && !inflight;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("dut%0d word_count", d), 32'(wc[d]), 32'(model_cnt));
        chk($sformatf("dut%0d valid", d), 32'(bv[d]), 32'(exp_valid));
        chk($sformatf("dut%0d remove", d), 32'(rm[d]), 32'(exp_remove));
      end
      if (exp_valid) begin
        b = exp_q[0];
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("dut%0d beat%0d", d, b.k), 32'(bo[d]), 32'(beat_of(b.w, b.k, d == 1)));
          chk($sformatf("dut%0d last", d), 32'(bl[d]), 32'(b.last));
        end
        if (byte_ready) begin
          void'(exp_q.pop_front());
          beats_done++;
          if (b.last) begin
            model_cnt++;
            inflight = 0;
          end
        end
      end
      // Flush throws away whatever remains of the held word.
      if (sync_flush && inflight) begin
        exp_q.delete();
        inflight = 0;
      end
      pop_pending = exp_remove;
      if (exp_remove) begin
        for (int k = 0; k < R; k++) exp_q.push_back('{w: fifo_q[0], k: k, last: (k == R - 1)});
        inflight   = 1;
        pop_cyc    = cyc;
        beats_done = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_out);
    #1;
    empty = (fifo_q.size() == 0) || hide;
  endtask

  // mode 0: drained and idle; 1: presenting beat n; 2: in the cycle after a pop
  task automatic wait_for(input int mode, input int n);
    bit hit;
    for (int i = 0; i < 60; i++) begin
      case (mode)
        0: hit = !inflight && fifo_q.size() == 0;
        1: hit = inflight && beats_done == n && cyc > pop_cyc;
        default: hit = inflight && cyc == pop_cyc;
      endcase
      if (hit) return;
      tick();
    end
    checks++;
    failures++;
    $display("FAIL wait mode%0d: got timeout expected condition", mode);
  endtask

  initial begin
    rst = 0; sync_flush = 0; byte_ready = 1; empty = 0;
    fifo_q.push_back(32'hA1B2C3D4);
    repeat (3) tick();
    empty = 0;
    rst = 1;
    repeat (8) tick();

    // Backpressure on beat 1.
    fifo_q.push_back(32'hA1B2C3D4);
    empty = 0;
    wait_for(1, 1);
    byte_ready = 0;
    repeat (4) tick();
    byte_ready = 1;
    wait_for(0, 0);
    repeat (2) tick();

    // Back-to-back words.
    for (int i = 0; i < 3; i++) fifo_q.push_back(32'h1000_0000 * (i + 1) + 32'h0102_0304);
    empty = 0;
    repeat (20) tick();
    wait_for(0, 0);

    // Flush on beat 2, then the next word starts clean.
    fifo_q.push_back(32'hDEADBEEF);
    empty = 0;
    wait_for(1, 2);
    sync_flush = 1;
    tick();
    sync_flush = 0;
    fifo_q.push_back(32'h0BADF00D);
    empty = 0;
    wait_for(0, 0);
    repeat (2) tick();

    // Flush in WAIT discards the popped word.
    fifo_q.push_back(32'hCAFEF00D);
    empty = 0;
    wait_for(2, 0);
    sync_flush = 1;
    tick();
    sync_flush = 0;
    repeat (4) tick();

    // Counter wrap.
    wait_for(0, 0);
    force u_dut0.word_count_q = 16'hFFFF;
    force u_dut1.word_count_q = 16'hFFFF;
    model_cnt = 16'hFFFF;
    #1;
    release u_dut0.word_count_q;
    release u_dut1.word_count_q;
    fifo_q.push_back(32'h55AA_33CC);
    tick();
    wait_for(0, 0);
    tick();
    chk("wrap dut0", 32'(wc[0]), 0);
    chk("wrap dut1", 32'(wc[1]), 0);

    // Random traffic with backpressure, flushes and empty glitches.
    for (int i = 0; i < 3000; i++) begin
      if (fifo_q.size() < 4 && $urandom_range(0, 2) == 0) fifo_q.push_back($urandom);
      byte_ready = ($urandom_range(0, 3) != 0);
      sync_flush = ($urandom_range(0, 39) == 0);
      hide       = ($urandom_range(0, 7) == 0);
      tick();
    end
    sync_flush = 0; hide = 0; byte_ready = 1;

    // Asynchronous reset in the middle of a word.
    fifo_q.push_back(32'h1234_5678);
    tick();
    wait_for(1, 1);
    rst = 0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("async rst dut%0d valid", d), 32'(bv[d]), 0);
      chk($sformatf("async rst dut%0d count", d), 32'(wc[d]), 0);
    end
    repeat (2) tick();
    rst = 1;
    fifo_q.push_back(32'h8765_4321);
    tick();
    wait_for(0, 0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
